alu_op_issue: RTL and testbench

- Registered decode/issue stage that drives the ALU control interface of the RV32 core.
- Accepts a raw RV32I instruction word plus PC over a valid/ready handshake.
- Produces the 4-bit ALU control code, operand selects, immediate and register indices.
- A 2-entry skid buffer gives full throughput under back-pressure from the execute stage.

---
 rtl/alu_op_issue_if.sv | 40 ++++
 rtl/alu_op_issue.sv | 197 +++++++++++++++++++
 tb/tb_alu_op_issue.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_if.sv
// Instruction-in / decoded-op-out handshake bundle for the ALU issue stage.
// master drives instructions and out_ready; slave is the issue stage.
interface alu_op_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_control;
  logic [1:0]            out_srca_sel;
  logic                  out_srcb_sel;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic                  out_reg_write;
  logic                  out_is_branch;
  logic [2:0]            out_br_funct3;
  logic                  out_illegal;
  logic [DATA_WIDTH-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_control, out_srca_sel, out_srcb_sel, out_imm,
           out_rd, out_rs1, out_rs2, out_reg_write, out_is_branch, out_br_funct3,
           out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_control, out_srca_sel, out_srcb_sel, out_imm,
           out_rd, out_rs1, out_rs2, out_reg_write, out_is_branch, out_br_funct3,
           out_illegal, out_pc
  );
endinterface

// File: rtl/alu_op_issue.sv
// RV32I decode/issue stage: 1-cycle accept-to-output latency, full throughput.
// Back-pressure absorbed by a skid entry; in_ready = !skid_vld (registered).
module alu_op_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  alu_op_issue_if.slave   bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010, ALU_SLT = 4'b0011,
    ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
    ALU_OR   = 4'b1000, ALU_AND = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [3:0]            control;
    logic [1:0]            srca_sel;
    logic                  srcb_sel;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  reg_write;
    logic                  is_branch;
    logic [2:0]            br_funct3;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] pc;
  } op_t;

  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

  op_t               dec;
  op_t               op_q;
  op_t               skid_q;
  logic              op_vld;
  logic              skid_vld;
  logic              accept;
  logic [31:0]       ins;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic signed [31:0] imm32;
  logic              ill;

  always_comb begin
    dec           = '0;
    imm32         = '0;
    ill           = 1'b0;
    ins           = bus.in_instr[31:0];
    f3            = ins[14:12];
    f7            = ins[31:25];
    dec.rd        = REG_ADDR_W'(ins[11:7]);
    dec.rs1       = REG_ADDR_W'(ins[19:15]);
    dec.rs2       = REG_ADDR_W'(ins[24:20]);
    dec.br_funct3 = f3;
    dec.pc        = bus.in_pc;
    dec.control   = ALU_ADD;
    case (ins[6:0])
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000)                       dec.control = f3_ctrl(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)  dec.control = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)  dec.control = ALU_SRA;
        else                                        ill = 1'b1;
      end
      OPC_OPIMM: begin
        dec.srcb_sel  = 1'b1;
        dec.reg_write = 1'b1;
        dec.control   = f3_ctrl(f3);
        imm32         = {{20{ins[31]}}, ins[31:20]};
        // Shift-immediates carry funct7 in imm[11:5]; only shamt reaches the ALU.
        if (f3 == 3'b001) begin
          imm32 = {27'b0, ins[24:20]};
          if (f7 != 7'b0000000) ill = 1'b1;
        end else if (f3 == 3'b101) begin
          imm32 = {27'b0, ins[24:20]};
          if (f7 == 7'b0100000)      dec.control = ALU_SRA;
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.srca_sel  = (ins[6:0] == OPC_LUI) ? 2'b10 : 2'b01;
        dec.srcb_sel  = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.srca_sel  = 2'b01;
        dec.srcb_sel  = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.srcb_sel  = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{20{ins[31]}}, ins[31:20]};
        if (f3 != 3'b000) ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        imm32         = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        case (f3[2:1])
          2'b00:   dec.control = ALU_SUB;
          2'b10:   dec.control = ALU_SLT;
          2'b11:   dec.control = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.srcb_sel  = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        dec.srcb_sel  = 1'b1;
        imm32         = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      default: ill = 1'b1;
    endcase
    dec.imm = DATA_WIDTH'(imm32);
    // Illegal ops still flow downstream, but must be architecturally inert.
    if (ill) begin
      dec.illegal   = 1'b1;
      dec.control   = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.srca_sel  = 2'b00;
      dec.srcb_sel  = 1'b0;
      dec.imm       = '0;
    end
  end

  assign accept = bus.in_valid && !skid_vld;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q     <= '0;
      skid_q   <= '0;
      op_vld   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!op_vld || bus.out_ready) begin
      // accept and skid_vld are exclusive, so at most one source loads the output.
      if (skid_vld) begin
        op_q     <= skid_q;
        op_vld   <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        op_q   <= dec;
        op_vld <= 1'b1;
      end else begin
        op_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready      = !skid_vld;
  assign bus.out_valid     = op_vld;
  assign bus.out_control   = op_q.control;
  assign bus.out_srca_sel  = op_q.srca_sel;
  assign bus.out_srcb_sel  = op_q.srcb_sel;
  assign bus.out_imm       = op_q.imm;
  assign bus.out_rd        = op_q.rd;
  assign bus.out_rs1       = op_q.rs1;
  assign bus.out_rs2       = op_q.rs2;
  assign bus.out_reg_write = op_q.reg_write;
  assign bus.out_is_branch = op_q.is_branch;
  assign bus.out_br_funct3 = op_q.br_funct3;
  assign bus.out_illegal   = op_q.illegal;
  assign bus.out_pc        = op_q.pc;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: decode vector table streamed through a scoreboard,
// plus back-pressure and reset-while-full sequences.
module tb_alu_op_issue;

  typedef struct packed {
    logic [3:0]  control;
    logic [1:0]  srca;
    logic        srcb;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        br;
    logic [2:0]  f3;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vt[16];

  alu_op_issue_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) bus ();

  alu_op_issue #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] c, input logic [1:0] a, input logic b,
                              input logic [31:0] imm, input int rd, input int rs1,
                              input int rs2, input logic rw, input logic br,
                              input logic [2:0] f3, input logic ill);
    exp_t e;
    e.control = c;  e.srca = a;  e.srcb = b;  e.imm = imm;
    e.rd = 5'(rd);  e.rs1 = 5'(rs1);  e.rs2 = 5'(rs2);
    e.rw = rw;  e.br = br;  e.f3 = f3;  e.ill = ill;  e.pc = '0;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.control = bus.out_control;  a.srca = bus.out_srca_sel;  a.srcb = bus.out_srcb_sel;
    a.imm = bus.out_imm;  a.rd = bus.out_rd;  a.rs1 = bus.out_rs1;  a.rs2 = bus.out_rs2;
    a.rw = bus.out_reg_write;  a.br = bus.out_is_branch;  a.f3 = bus.out_br_funct3;
    a.ill = bus.out_illegal;  a.pc = bus.out_pc;
    return a;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_op(input exp_t e);
    exp_t a;
    a = actual();
    // Operand selects and immediate are don't-care on illegal ops.
    if (e.ill) begin
      a.srca = '0;  a.srcb = 1'b0;  a.imm = '0;
      e.srca = '0;  e.srcb = 1'b0;  e.imm = '0;
    end
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL op pc=%h: got %h, expected %h", e.pc, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got op pc=%h, expected no op", bus.out_pc);
      end else begin
        check_op(sb[0]);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      cmp("accept_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      e.pc = pc;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    cmp(nm, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h002081B3, mk(4'h0, 2'b00, 1'b0, 32'h0,        3,  1,  2, 1, 0, 3'd0, 0)};
    vt[1]  = '{32'h402081B3, mk(4'h1, 2'b00, 1'b0, 32'h0,        3,  1,  2, 1, 0, 3'd0, 0)};
    vt[2]  = '{32'h40335293, mk(4'h7, 2'b00, 1'b1, 32'h3,        5,  6,  3, 1, 0, 3'd5, 0)};
    vt[3]  = '{32'h123450B7, mk(4'h0, 2'b10, 1'b1, 32'h12345000, 1,  8,  3, 1, 0, 3'd5, 0)};
    vt[4]  = '{32'h00208463, mk(4'h1, 2'b00, 1'b0, 32'h8,        8,  1,  2, 0, 1, 3'd0, 0)};
    vt[5]  = '{32'hFFFFFFFF, mk(4'h0, 2'b00, 1'b0, 32'h0,        31, 31, 31, 0, 0, 3'd7, 1)};
    vt[6]  = '{32'hFFF10093, mk(4'h0, 2'b00, 1'b1, 32'hFFFFFFFF, 1,  2,  31, 1, 0, 3'd0, 0)};
    vt[7]  = '{32'h80000297, mk(4'h0, 2'b01, 1'b1, 32'h80000000, 5,  0,  0, 1, 0, 3'd0, 0)};
    vt[8]  = '{32'hFFDFF0EF, mk(4'h0, 2'b01, 1'b1, 32'hFFFFFFFC, 1,  31, 29, 1, 0, 3'd7, 0)};
    vt[9]  = '{32'hFE20AC23, mk(4'h0, 2'b00, 1'b1, 32'hFFFFFFF8, 24, 1,  2, 0, 0, 3'd2, 0)};
    vt[10] = '{32'h02109093, mk(4'h0, 2'b00, 1'b0, 32'h0,        1,  1,  1, 0, 0, 3'd1, 1)};
    vt[11] = '{32'h0020F463, mk(4'h4, 2'b00, 1'b0, 32'h8,        8,  1,  2, 0, 1, 3'd7, 0)};
    vt[12] = '{32'h0020A463, mk(4'h0, 2'b00, 1'b0, 32'h0,        8,  1,  2, 0, 0, 3'd2, 1)};
    vt[13] = '{32'h402091B3, mk(4'h0, 2'b00, 1'b0, 32'h0,        3,  1,  2, 0, 0, 3'd1, 1)};
    vt[14] = '{32'h0020F1B3, mk(4'h9, 2'b00, 1'b0, 32'h0,        3,  1,  2, 1, 0, 3'd7, 0)};
    vt[15] = '{32'h0020B1B3, mk(4'h4, 2'b00, 1'b0, 32'h0,        3,  1,  2, 1, 0, 3'd3, 0)};

    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    cmp("rst_out_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst_in_ready",  32'(bus.in_ready),  32'd1);
    cmp("rst_control",   32'(bus.out_control), 32'd0);
    cmp("rst_imm",       bus.out_imm, 32'd0);

    // Decode table, streamed back to back at full rate.
    for (int i = 0; i < 16; i++) begin
      send(vt[i].instr, 32'h1000 + 32'(4 * i), vt[i].e);
      if (i == 0) cmp("latency_out_valid", 32'(bus.out_valid), 32'd1);
    end
    drain("table_drain");

    // Back-pressure: four ops with the execute stage stalled for three cycles.
    bus.out_ready = 1'b0;
    fork
      begin
        send(vt[14].instr, 32'h2000, vt[14].e);
        cmp("bp_in_ready_1", 32'(bus.in_ready), 32'd1);
        send(vt[2].instr,  32'h2004, vt[2].e);
        cmp("bp_in_ready_2", 32'(bus.in_ready), 32'd0);
        send(vt[8].instr,  32'h2008, vt[8].e);
        send(vt[4].instr,  32'h200C, vt[4].e);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with both entries occupied must discard everything.
    bus.out_ready = 1'b0;
    send(vt[1].instr, 32'h3000, vt[1].e);
    send(vt[3].instr, 32'h3004, vt[3].e);
    cmp("full_in_ready", 32'(bus.in_ready), 32'd0);
    rstn = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    cmp("rst_full_out_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst_full_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmp("rst_no_stale", 32'(bus.out_valid), 32'd0);
    send(vt[9].instr, 32'h4000, vt[9].e);
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
